rd_addr_arbiter: RTL and testbench

RD_ADDR_ARBITER -- requirements
Module: rd_addr_arbiter

---
 rtl/rd_addr_arbiter.sv | 150 +++++++++++++++
 tb/tb_rd_addr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rd_addr_arbiter.sv
// Read-address arbiter: grants one of four masters the shared AR/R path and holds the grant until its bursts drain.
// Define RD_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (master 0 highest).
module rd_addr_arbiter #(
  parameter int MAX_OUTS = 4,
  parameter int CNT_W    = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [3:0]       s_arvalid,
  output logic [3:0]       s_arready,
  output logic             m_arvalid,
  input  logic             m_arready,
  input  logic             m_rvalid,
  input  logic             m_rlast,
  input  logic             s_rready,
  output logic [1:0]       ar_sel,
  output logic [3:0]       ar_grant,
  output logic [CNT_W-1:0] outs_cnt,
  output logic             rd_state_refre
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_OUTS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next, win_idx;
  logic [3:0]       grant_reg, grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             any_req, req_sel, below_max, ar_hs, r_done, cnt_inc, cnt_dec;

  assign any_req   = |s_arvalid;
  assign req_sel   = s_arvalid[sel_reg];
  assign below_max = (cnt_reg < MAX_C);
  assign m_arvalid = (state_reg == GRANT) && req_sel && below_max;
  assign ar_hs     = m_arvalid && m_arready;
  assign r_done    = m_rvalid && s_rready && m_rlast;
  assign cnt_inc   = ar_hs;
  assign cnt_dec   = r_done && (cnt_reg != CNT_ZERO);

  always_comb begin
    s_arready = 4'b0000;
    if (state_reg == GRANT)
      s_arready[sel_reg] = m_arready && below_max;
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_inc && !cnt_dec)
      cnt_next = cnt_reg + CNT_ONE;
    else if (cnt_dec && !cnt_inc)
      cnt_next = cnt_reg - CNT_ONE;
  end

`ifdef RD_ARB_RR_EN
  // ptr_reg is the first index searched: one past the last winner.
  logic [1:0] ptr_reg;
  logic [1:0] rr_cand;

  always_comb begin
    win_idx = ptr_reg;
    rr_cand = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      rr_cand = ptr_reg + 2'(k);
      if (s_arvalid[rr_cand])
        win_idx = rr_cand;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      ptr_reg <= 2'd0;
    else if (state_reg == IDLE && any_req)
      ptr_reg <= win_idx + 2'd1;
  end
`else
  always_comb begin
    win_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (s_arvalid[k])
        win_idx = 2'(k);
    end
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      grant_reg <= 4'b0000;
      cnt_reg   <= CNT_ZERO;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Exit decisions look at cnt_next so a completion landing in the same cycle cannot strand the FSM.
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    grant_next     = grant_reg;
    rd_state_refre = 1'b0;
    case (state_reg)
      IDLE: begin
        grant_next = 4'b0000;
        if (any_req) begin
          sel_next   = win_idx;
          grant_next = 4'b0001 << win_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (cnt_next == MAX_C) begin
          state_next = WAIT_DONE;
        end else if (!req_sel) begin
          if (cnt_next == CNT_ZERO) begin
            state_next     = IDLE;
            grant_next     = 4'b0000;
            rd_state_refre = 1'b1;
          end else begin
            state_next = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (cnt_next == CNT_ZERO) begin
          state_next     = IDLE;
          grant_next     = 4'b0000;
          rd_state_refre = 1'b1;
        end else if (req_sel && below_max) begin
          state_next = GRANT;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  assign ar_sel   = sel_reg;
  assign ar_grant = grant_reg;
  assign outs_cnt = cnt_reg;

endmodule

// File: tb/tb_rd_addr_arbiter.sv
// Directed bench for rd_addr_arbiter: single request, contention, saturation, overlap, no-preemption, reset.
module tb_rd_addr_arbiter;

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] s_arvalid;
  logic [3:0] s_arready;
  logic       m_arvalid;
  logic       m_arready;
  logic       m_rvalid;
  logic       m_rlast;
  logic       s_rready;
  logic [1:0] ar_sel;
  logic [3:0] ar_grant;
  logic [2:0] outs_cnt;
  logic       rd_state_refre;

  int n_cmp = 0;
  int n_err = 0;

  rd_addr_arbiter #(.MAX_OUTS(4), .CNT_W(3)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .s_arvalid      (s_arvalid),
    .s_arready      (s_arready),
    .m_arvalid      (m_arvalid),
    .m_arready      (m_arready),
    .m_rvalid       (m_rvalid),
    .m_rlast        (m_rlast),
    .s_rready       (s_rready),
    .ar_sel         (ar_sel),
    .ar_grant       (ar_grant),
    .outs_cnt       (outs_cnt),
    .rd_state_refre (rd_state_refre)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic set_r(input logic v);
    m_rvalid = v;
    m_rlast  = v;
    s_rready = v;
  endtask

  task automatic test_reset;
    @(negedge sys_clk); #1;
    n_cmp++; if (ar_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", ar_sel); end
    n_cmp++; if (ar_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", ar_grant); end
    n_cmp++; if (outs_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", outs_cnt); end
    n_cmp++; if ({m_arvalid, s_arready, rd_state_refre} !== 6'b0) begin n_err++; $display("FAIL reset_outs: got %b want 000000", {m_arvalid, s_arready, rd_state_refre}); end
    sys_rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single;
    @(negedge sys_clk);
    s_arvalid = 4'b0100; m_arready = 1'b1; #1;
    n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL single_idle_arvalid: got %b want 0", m_arvalid); end
    @(negedge sys_clk); #1;
    n_cmp++; if (ar_sel !== 2'd2) begin n_err++; $display("FAIL single_sel: got %0d want 2", ar_sel); end
    n_cmp++; if (ar_grant !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", ar_grant); end
    n_cmp++; if ({m_arvalid, s_arready} !== 5'b1_0100) begin n_err++; $display("FAIL single_ar: got %b want 10100", {m_arvalid, s_arready}); end
    @(negedge sys_clk); #1;
    n_cmp++; if (outs_cnt !== 3'd1) begin n_err++; $display("FAIL single_cnt1: got %0d want 1", outs_cnt); end
    @(negedge sys_clk); #1;
    n_cmp++; if (outs_cnt !== 3'd2) begin n_err++; $display("FAIL single_cnt2: got %0d want 2", outs_cnt); end
    s_arvalid = 4'b0000; #1;
    n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL single_drop_arvalid: got %b want 0", m_arvalid); end
    @(negedge sys_clk);
    set_r(1'b1); #1;
    n_cmp++; if (rd_state_refre !== 1'b0) begin n_err++; $display("FAIL single_refre_early: got %b want 0", rd_state_refre); end
    @(negedge sys_clk); #1;
    n_cmp++; if (outs_cnt !== 3'd1) begin n_err++; $display("FAIL single_cnt_dec: got %0d want 1", outs_cnt); end
    n_cmp++; if (rd_state_refre !== 1'b1) begin n_err++; $display("FAIL single_refre: got %b want 1", rd_state_refre); end
    @(negedge sys_clk);
    set_r(1'b0); #1;
    n_cmp++; if (outs_cnt !== 3'd0) begin n_err++; $display("FAIL single_cnt0: got %0d want 0", outs_cnt); end
    n_cmp++; if (ar_grant !== 4'b0000) begin n_err++; $display("FAIL single_release: got %b want 0000", ar_grant); end
    n_cmp++; if (ar_sel !== 2'd2) begin n_err++; $display("FAIL single_sel_hold: got %0d want 2", ar_sel); end
    n_cmp++; if (rd_state_refre !== 1'b0) begin n_err++; $display("FAIL single_refre_once: got %b want 0", rd_state_refre); end
    m_arready = 1'b0;
    $display("test_single done");
  endtask

  task automatic test_contention;
    int         exp_order [5];
    int         n_grants;
    logic [3:0] exp_g;
`ifdef RD_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
    n_grants  = 5;
`else
    exp_order = '{0, 0, 0, 0, 0};
    n_grants  = 3;
`endif
    for (int g = 0; g < n_grants; g++) begin
      @(negedge sys_clk);
      s_arvalid = 4'b1111; m_arready = 1'b1; set_r(1'b0);
      exp_g = 4'b0001 << exp_order[g];
      @(negedge sys_clk); #1;
      n_cmp++; if (ar_sel !== 2'(exp_order[g])) begin n_err++; $display("FAIL contention_sel[%0d]: got %0d want %0d", g, ar_sel, exp_order[g]); end
      n_cmp++; if (ar_grant !== exp_g) begin n_err++; $display("FAIL contention_grant[%0d]: got %b want %b", g, ar_grant, exp_g); end
      @(negedge sys_clk);
      s_arvalid = 4'b1111 & ~exp_g;
      @(negedge sys_clk);
      set_r(1'b1);
      $display("contention grant %0d -> master %0d", g, ar_sel);
    end
    @(negedge sys_clk);
    set_r(1'b0); s_arvalid = 4'b0000; m_arready = 1'b0; #1;
    n_cmp++; if (outs_cnt !== 3'd0) begin n_err++; $display("FAIL contention_cnt: got %0d want 0", outs_cnt); end
    n_cmp++; if (ar_grant !== 4'b0000) begin n_err++; $display("FAIL contention_release: got %b want 0000", ar_grant); end
  endtask

  task automatic test_saturation;
    int hs = 0;
    int pulses = 0;
    @(negedge sys_clk);
    s_arvalid = 4'b0010; m_arready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk); #1;
      if (m_arvalid && m_arready) hs++;
    end
    n_cmp++; if (hs !== 4) begin n_err++; $display("FAIL sat_handshakes: got %0d want 4", hs); end
    n_cmp++; if (outs_cnt !== 3'd4) begin n_err++; $display("FAIL sat_cnt: got %0d want 4", outs_cnt); end
    n_cmp++; if ({m_arvalid, s_arready} !== 5'b0) begin n_err++; $display("FAIL sat_blocked: got %b want 00000", {m_arvalid, s_arready}); end
    n_cmp++; if (ar_grant !== 4'b0010) begin n_err++; $display("FAIL sat_grant: got %b want 0010", ar_grant); end
    s_arvalid = 4'b0000; m_arready = 1'b0; set_r(1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rd_state_refre) pulses++;
      @(negedge sys_clk);
    end
    set_r(1'b0); #1;
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL sat_refre_pulses: got %0d want 1", pulses); end
    n_cmp++; if (outs_cnt !== 3'd0) begin n_err++; $display("FAIL sat_drain_cnt: got %0d want 0", outs_cnt); end
    n_cmp++; if (ar_grant !== 4'b0000) begin n_err++; $display("FAIL sat_release: got %b want 0000", ar_grant); end
    $display("test_saturation done, %0d handshakes", hs);
  endtask

  task automatic test_simultaneous;
    @(negedge sys_clk);
    s_arvalid = 4'b1000; m_arready = 1'b1;
    repeat (3) @(negedge sys_clk);
    #1;
    n_cmp++; if (outs_cnt !== 3'd2) begin n_err++; $display("FAIL simul_pre_cnt: got %0d want 2", outs_cnt); end
    set_r(1'b1); #1;
    n_cmp++; if (m_arvalid !== 1'b1) begin n_err++; $display("FAIL simul_arvalid: got %b want 1", m_arvalid); end
    @(negedge sys_clk); #1;
    n_cmp++; if (outs_cnt !== 3'd2) begin n_err++; $display("FAIL simul_hold: got %0d want 2", outs_cnt); end
    s_arvalid = 4'b0000; m_arready = 1'b0;
    repeat (2) @(negedge sys_clk);
    set_r(1'b0); #1;
    n_cmp++; if (outs_cnt !== 3'd0) begin n_err++; $display("FAIL simul_drain_cnt: got %0d want 0", outs_cnt); end
    n_cmp++; if (ar_grant !== 4'b0000) begin n_err++; $display("FAIL simul_release: got %b want 0000", ar_grant); end
    $display("test_simultaneous done");
  endtask

  task automatic test_no_preempt;
    @(negedge sys_clk);
    s_arvalid = 4'b0010; m_arready = 1'b1;
    repeat (4) @(negedge sys_clk);
    #1;
    n_cmp++; if (outs_cnt !== 3'd3) begin n_err++; $display("FAIL nopre_cnt3: got %0d want 3", outs_cnt); end
    s_arvalid = 4'b0001; m_arready = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ar_grant !== 4'b0010) begin n_err++; $display("FAIL nopre_grant[%0d]: got %b want 0010", i, ar_grant); end
      n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL nopre_arvalid[%0d]: got %b want 0", i, m_arvalid); end
      set_r(1'b1); #1;
      n_cmp++; if (rd_state_refre !== (i == 2)) begin n_err++; $display("FAIL nopre_refre[%0d]: got %b want %b", i, rd_state_refre, (i == 2)); end
      @(negedge sys_clk);
    end
    set_r(1'b0); #1;
    n_cmp++; if (ar_grant !== 4'b0000) begin n_err++; $display("FAIL nopre_idle: got %b want 0000", ar_grant); end
    @(negedge sys_clk); #1;
    n_cmp++; if (ar_sel !== 2'd0) begin n_err++; $display("FAIL nopre_new_sel: got %0d want 0", ar_sel); end
    n_cmp++; if (ar_grant !== 4'b0001) begin n_err++; $display("FAIL nopre_new_grant: got %b want 0001", ar_grant); end
    s_arvalid = 4'b0000; #1;
    n_cmp++; if (rd_state_refre !== 1'b1) begin n_err++; $display("FAIL nopre_drop_refre: got %b want 1", rd_state_refre); end
    @(negedge sys_clk); #1;
    n_cmp++; if (ar_grant !== 4'b0000) begin n_err++; $display("FAIL nopre_drop_release: got %b want 0000", ar_grant); end
    $display("test_no_preempt done");
  endtask

  task automatic test_reset_mid;
    @(negedge sys_clk);
    s_arvalid = 4'b0100; m_arready = 1'b1;
    repeat (4) @(negedge sys_clk);
    #1;
    n_cmp++; if (outs_cnt !== 3'd3) begin n_err++; $display("FAIL rstmid_pre_cnt: got %0d want 3", outs_cnt); end
    #1 sys_rst = 1'b1;
    #1;
    n_cmp++; if (outs_cnt !== 3'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 0", outs_cnt); end
    n_cmp++; if ({ar_sel, ar_grant} !== 6'b0) begin n_err++; $display("FAIL rstmid_grant: got %b want 000000", {ar_sel, ar_grant}); end
    n_cmp++; if ({m_arvalid, s_arready, rd_state_refre} !== 6'b0) begin n_err++; $display("FAIL rstmid_outs: got %b want 000000", {m_arvalid, s_arready, rd_state_refre}); end
    s_arvalid = 4'b0000; m_arready = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    set_r(1'b1); #1;
    n_cmp++; if (rd_state_refre !== 1'b0) begin n_err++; $display("FAIL rstmid_stray_refre: got %b want 0", rd_state_refre); end
    @(negedge sys_clk);
    set_r(1'b0); #1;
    n_cmp++; if (outs_cnt !== 3'd0) begin n_err++; $display("FAIL rstmid_stray_cnt: got %0d want 0", outs_cnt); end
    $display("test_reset_mid done");
  endtask

  initial begin
    sys_rst   = 1'b1;
    s_arvalid = 4'b0000;
    m_arready = 1'b0;
    set_r(1'b0);
    test_reset;
    test_single;
    test_contention;
    test_saturation;
    test_simultaneous;
    test_no_preempt;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
